wb_timer16: RTL and testbench



---
 rtl/wb_timer16.sv | 168 ++++++++++++++++
 tb/tb_wb_timer16.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer16.sv
// 16-bit WISHBONE timer/counter: prescaled up-counter with compare/clear-on-match,
// overflow and compare flags, and an interrupt request released by the CPU acknowledge.
module wb_timer16 #(
    parameter logic [7:0] ADR_BASE = 8'h00,
    parameter int         PRESC_W  = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    output logic       wb_ack_o,
    output logic       irq_req_o,
    input  logic       irq_ack_i
);
    localparam logic [2:0] IDX_CTRL = 3'd0;
    localparam logic [2:0] IDX_STAT = 3'd1;
    localparam logic [2:0] IDX_CNTL = 3'd2;
    localparam logic [2:0] IDX_CNTH = 3'd3;
    localparam logic [2:0] IDX_CMPL = 3'd4;
    localparam logic [2:0] IDX_CMPH = 3'd5;

    logic [2:0]         cs_q, cs_d;
    logic               ctc_q, ctc_d;
    logic               cmpie_q, cmpie_d;
    logic               ovfie_q, ovfie_d;
    logic               ovf_q, ovf_d;
    logic               cmpf_q, cmpf_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        cmp_q, cmp_d;
    logic [7:0]         temp_q, temp_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               ack_q, ack_d;
    logic [7:0]         dat_q, dat_d;
    logic               irq_q, irq_d;

    logic       acc, wr, rd, run, tick, psr_wr;
    logic       ovf_set, cmpf_set, ovf_clr, cmpf_clr;
    logic [2:0] idx;

    // Bus access decode; a held strobe is re-accepted only after the ack cycle.
    always_comb begin
        idx = wb_adr_i[2:0];
        acc = wb_stb_i && (wb_adr_i[7:3] == ADR_BASE[7:3]) && !ack_q;
        wr  = acc && wb_we_i;
        rd  = acc && !wb_we_i;
    end

    always_comb begin
        run = (cs_q >= 3'd1) && (cs_q <= 3'd5);
        case (cs_q)
            3'd1:    tick = 1'b1;
            3'd2:    tick = &presc_q[2:0];
            3'd3:    tick = &presc_q[5:0];
            3'd4:    tick = &presc_q[7:0];
            3'd5:    tick = &presc_q[9:0];
            default: tick = 1'b0;
        endcase
        psr_wr  = wr && (idx == IDX_CTRL) && wb_dat_i[6];
        presc_d = (!run || psr_wr) ? '0 : presc_q + PRESC_W'(1);
    end

    always_comb begin
        cs_d     = cs_q;
        ctc_d    = ctc_q;
        cmpie_d  = cmpie_q;
        ovfie_d  = ovfie_q;
        cnt_d    = cnt_q;
        cmp_d    = cmp_q;
        temp_d   = temp_q;
        cmpf_set = 1'b0;
        ovf_set  = 1'b0;
        cmpf_clr = 1'b0;
        ovf_clr  = 1'b0;
        dat_d    = 8'h00;

        // Overflow fires whenever a tick leaves 16'hFFFF, whether by wrap or by CTC clear.
        if (tick) begin
            cmpf_set = (cnt_q == cmp_q);
            ovf_set  = (cnt_q == 16'hFFFF);
            cnt_d    = (ctc_q && (cnt_q == cmp_q)) ? 16'h0000 : cnt_q + 16'd1;
        end

        if (wr) begin
            case (idx)
                IDX_CTRL: {ovfie_d, cmpie_d, ctc_d, cs_d} = wb_dat_i[5:0];
                IDX_STAT: begin
                    ovf_clr  = wb_dat_i[0];
                    cmpf_clr = wb_dat_i[1];
                end
                IDX_CNTL: begin
                    cnt_d    = {temp_q, wb_dat_i};
                    cmpf_set = 1'b0;
                    ovf_set  = 1'b0;
                end
                IDX_CNTH, IDX_CMPH: temp_d = wb_dat_i;
                IDX_CMPL: cmp_d = {temp_q, wb_dat_i};
                default: ;
            endcase
        end

        if (rd) begin
            case (idx)
                IDX_CTRL: dat_d = {2'b00, ovfie_q, cmpie_q, ctc_q, cs_q};
                IDX_STAT: dat_d = {6'b000000, cmpf_q, ovf_q};
                IDX_CNTL: begin
                    dat_d  = cnt_q[7:0];
                    temp_d = cnt_q[15:8];
                end
                IDX_CNTH: dat_d = temp_q;
                IDX_CMPL: dat_d = cmp_q[7:0];
                IDX_CMPH: dat_d = cmp_q[15:8];
                default:  dat_d = 8'h00;
            endcase
        end

        if (irq_ack_i) begin
            if (cmpf_q && cmpie_q)
                cmpf_clr = 1'b1;
            else if (ovf_q && ovfie_q)
                ovf_clr = 1'b1;
        end

        // A hardware set outranks any clear in the same cycle.
        cmpf_d = (cmpf_q && !cmpf_clr) || cmpf_set;
        ovf_d  = (ovf_q && !ovf_clr) || ovf_set;
        irq_d  = (cmpf_q && cmpie_q) || (ovf_q && ovfie_q);
        ack_d  = acc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_q    <= 3'd0;
            ctc_q   <= 1'b0;
            cmpie_q <= 1'b0;
            ovfie_q <= 1'b0;
            ovf_q   <= 1'b0;
            cmpf_q  <= 1'b0;
            cnt_q   <= 16'h0000;
            cmp_q   <= 16'h0000;
            temp_q  <= 8'h00;
            presc_q <= '0;
            ack_q   <= 1'b0;
            dat_q   <= 8'h00;
            irq_q   <= 1'b0;
        end else begin
            cs_q    <= cs_d;
            ctc_q   <= ctc_d;
            cmpie_q <= cmpie_d;
            ovfie_q <= ovfie_d;
            ovf_q   <= ovf_d;
            cmpf_q  <= cmpf_d;
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            temp_q  <= temp_d;
            presc_q <= presc_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            irq_q   <= irq_d;
        end
    end

    assign wb_dat_o  = dat_q;
    assign wb_ack_o  = ack_q;
    assign irq_req_o = irq_q;
endmodule

// File: tb/tb_wb_timer16.sv
// Directed bench for wb_timer16: bus handshake, 16-bit access, compare/overflow,
// interrupt acknowledge, flag priority, prescaler reset and load-vs-tick.
module tb_wb_timer16;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic       wb_ack_o;
    logic       irq_req_o;
    logic       irq_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_STAT = 8'h01;
    localparam logic [7:0] A_CNTL = 8'h02;
    localparam logic [7:0] A_CNTH = 8'h03;
    localparam logic [7:0] A_CMPL = 8'h04;
    localparam logic [7:0] A_CMPH = 8'h05;

    wb_timer16 #(.ADR_BASE(8'h00), .PRESC_W(10)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_ack_o  (wb_ack_o),
        .irq_req_o (irq_req_o),
        .irq_ack_i (irq_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("  ok %s: %h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Called at a negedge; one strobe cycle, ack expected next cycle, then one idle cycle.
    task automatic xfer(input logic [7:0] a, input logic we, input logic [7:0] wd,
                        output logic [7:0] rdat);
        wb_adr_i = a;
        wb_dat_i = wd;
        wb_we_i  = we;
        wb_stb_i = 1'b1;
        @(negedge clk_i);
        check("ack_hi", 16'(wb_ack_o), 16'd1);
        rdat     = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk_i);
        check("ack_lo", 16'(wb_ack_o), 16'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] unused;
        xfer(a, 1'b1, d, unused);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] v;
        xfer(a, 1'b0, 8'h00, v);
        check(tag, 16'(v), 16'(exp));
    endtask

    task automatic irq_ack_pulse();
        irq_ack_i = 1'b1;
        @(negedge clk_i);
        irq_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; wb_adr_i = 8'h00; wb_dat_i = 8'h00;
        wb_stb_i = 1'b0; wb_we_i = 1'b0; irq_ack_i = 1'b0;
        idle(2);
        rst_i = 1'b0;
        check("rst_ack", 16'(wb_ack_o), 16'd0);
        check("rst_irq", 16'(irq_req_o), 16'd0);
        check("rst_dat", 16'(wb_dat_o), 16'd0);

        // Run with cmp=0 so CMPF/irq come up, then reset mid-transaction.
        wr(A_CTRL, 8'h11);
        idle(3);
        check("pre_rst_irq", 16'(irq_req_o), 16'd1);
        wb_adr_i = A_CNTL; wb_we_i = 1'b0; wb_stb_i = 1'b1;
        @(negedge clk_i);
        check("pre_rst_ack", 16'(wb_ack_o), 16'd1);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_ack", 16'(wb_ack_o), 16'd0);
        check("async_rst_irq", 16'(irq_req_o), 16'd0);
        check("async_rst_dat", 16'(wb_dat_o), 16'd0);
        wb_stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        rd_chk("rst_cntl", A_CNTL, 8'h00);
        rd_chk("rst_cnth", A_CNTH, 8'h00);
        rd_chk("rst_stat", A_STAT, 8'h00);
        rd_chk("rst_ctrl", A_CTRL, 8'h00);

        // 16-bit access through TEMP, unused index, held strobe, foreign address.
        wr(A_CNTH, 8'h12);
        wr(A_CNTL, 8'h34);
        wr(A_CTRL, 8'h00);
        rd_chk("cntl_34", A_CNTL, 8'h34);
        rd_chk("cnth_12", A_CNTH, 8'h12);
        rd_chk("idx6_zero", 8'h06, 8'h00);
        wb_adr_i = 8'h07; wb_we_i = 1'b0; wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check($sformatf("held_stb_ack%0d", i), 16'(wb_ack_o), 16'((i % 2) == 0));
        end
        wb_stb_i = 1'b0;
        idle(1);
        wb_adr_i = 8'h0A; wb_stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check($sformatf("foreign_ack%0d", i), 16'(wb_ack_o), 16'd0);
            check($sformatf("foreign_dat%0d", i), 16'(wb_dat_o), 16'd0);
        end
        wb_stb_i = 1'b0;
        idle(1);

        // CTC with cmp=4 at /1: cnt 0,1,2,3,4,0 repeating.
        wr(A_CNTH, 8'h00);
        wr(A_CNTL, 8'h00);
        wr(A_CMPH, 8'h00);
        wr(A_CMPL, 8'h04);
        wr(A_CTRL, 8'h19);
        rd_chk("ctc_cnt1", A_CNTL, 8'h01);
        rd_chk("ctc_cnt3", A_CNTL, 8'h03);
        check("ctc_irq_lag", 16'(irq_req_o), 16'd0);
        rd_chk("ctc_cnt0", A_CNTL, 8'h00);
        check("ctc_irq", 16'(irq_req_o), 16'd1);
        rd_chk("ctc_stat", A_STAT, 8'h02);
        wr(A_CTRL, 8'h18);
        check("ctc_irq_held", 16'(irq_req_o), 16'd1);
        irq_ack_pulse();
        check("ack_irq_lag", 16'(irq_req_o), 16'd1);
        idle(1);
        check("ack_irq_drop", 16'(irq_req_o), 16'd0);
        rd_chk("ack_stat", A_STAT, 8'h00);
        rd_chk("ctc_stopped", A_CNTL, 8'h00);

        // Overflow at /8 from 16'hFFFE.
        wr(A_CTRL, 8'h00);
        wr(A_CNTH, 8'hFF);
        wr(A_CNTL, 8'hFE);
        wr(A_CTRL, 8'h22);
        idle(4);
        rd_chk("ovf_fe", A_CNTL, 8'hFE);
        idle(1);
        rd_chk("ovf_ff", A_CNTL, 8'hFF);
        rd_chk("ovf_stat0", A_STAT, 8'h00);
        idle(4);
        check("ovf_irq_lag", 16'(irq_req_o), 16'd0);
        idle(1);
        check("ovf_irq", 16'(irq_req_o), 16'd1);
        rd_chk("ovf_stat1", A_STAT, 8'h01);
        rd_chk("ovf_wrap", A_CNTL, 8'h00);
        wr(A_STAT, 8'h01);
        check("ovf_clr_irq", 16'(irq_req_o), 16'd0);
        rd_chk("ovf_clr_stat", A_STAT, 8'h00);
        wr(A_CTRL, 8'h00);

        // Both flags from CTC at cmp=16'hFFFF; CMP acked first.
        wr(A_CNTH, 8'hFF);
        wr(A_CNTL, 8'hFF);
        wr(A_CMPH, 8'hFF);
        wr(A_CMPL, 8'hFF);
        wr(A_STAT, 8'h03);
        wr(A_CTRL, 8'h39);
        wr(A_CTRL, 8'h38);
        rd_chk("both_stat", A_STAT, 8'h03);
        check("both_irq", 16'(irq_req_o), 16'd1);
        irq_ack_pulse();
        idle(1);
        check("ack1_irq", 16'(irq_req_o), 16'd1);
        rd_chk("ack1_stat", A_STAT, 8'h01);
        irq_ack_pulse();
        idle(1);
        check("ack2_irq", 16'(irq_req_o), 16'd0);
        rd_chk("ack2_stat", A_STAT, 8'h00);

        // CMPF set by a /8 tick on the same edge as a STAT clear.
        wr(A_CNTH, 8'h00);
        wr(A_CNTL, 8'h00);
        wr(A_CMPH, 8'h00);
        wr(A_CMPL, 8'h00);
        wr(A_CTRL, 8'h0A);
        idle(6);
        wr(A_STAT, 8'h02);
        wr(A_CTRL, 8'h08);
        rd_chk("set_beats_clr", A_STAT, 8'h02);
        wr(A_STAT, 8'h03);

        // /1024 with a prescaler reset halfway, then a CNTL load on a tick edge.
        wr(A_CTRL, 8'h00);
        wr(A_CNTH, 8'h00);
        wr(A_CNTL, 8'h00);
        wr(A_CTRL, 8'h05);
        idle(510);
        wr(A_CTRL, 8'h45);
        rd_chk("psr_reads0", A_CTRL, 8'h05);
        idle(1020);
        rd_chk("psr_no_tick", A_CNTL, 8'h00);
        rd_chk("psr_tick", A_CNTL, 8'h01);
        wr(A_CNTH, 8'h56);
        idle(1018);
        wr(A_CNTL, 8'h78);
        wr(A_CTRL, 8'h00);
        rd_chk("load_wins_l", A_CNTL, 8'h78);
        rd_chk("load_wins_h", A_CNTH, 8'h56);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
